// File: rtl/fir_pkg.sv
// Shared constants, coefficient table and ring-index helper for the 31-tap
// symmetric FIR MAC scheduler.
package fir_pkg;

    localparam int unsigned DW    = 10;
    localparam int unsigned NTAPS = 31;
    localparam int unsigned NPAIR = (NTAPS + 1) / 2;
    localparam int unsigned CW    = 7;
    localparam int unsigned ACCW  = 21;
    localparam int unsigned SHIFT = 10;
    localparam int unsigned PW    = $clog2(NTAPS);
    localparam int unsigned KW    = $clog2(NPAIR);

    localparam logic [CW-1:0] COEF [NPAIR] = '{
        7'd3,  7'd4,  7'd6,  7'd8,  7'd12, 7'd17, 7'd23, 7'd29,
        7'd36, 7'd43, 7'd50, 7'd56, 7'd61, 7'd65, 7'd67, 7'd68
    };

    typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} fir_state_t;

    // (base - d) mod NTAPS; the ring is 31 deep, so wrap is handled explicitly
    function automatic logic [PW-1:0] ring_sub(input logic [PW-1:0] base,
                                               input logic [PW-1:0] d);
        logic [PW:0] t;
        if (base >= d) begin
            t = {1'b0, base - d};
        end else begin
            t = {1'b0, base} + (PW+1)'(NTAPS) - {1'b0, d};
        end
        return t[PW-1:0];
    endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// 31-entry sample history: one write port advancing a wrapping pointer,
// two combinational read ports for the symmetric tap pair.
module fir_sample_ring
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    input  logic [PW-1:0] idx_a,
    input  logic [PW-1:0] idx_b,
    output logic [DW-1:0] rdata_a_c,
    output logic [DW-1:0] rdata_b_c,
    output logic [PW-1:0] wptr
);

    logic [DW-1:0] mem [NTAPS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NTAPS); i++) begin
                mem[i] <= '0;
            end
            wptr <= '0;
        end else if (we) begin
            mem[wptr] <= wdata;
            wptr      <= (wptr == PW'(NTAPS - 1)) ? '0 : wptr + PW'(1);
        end
    end

    assign rdata_a_c = mem[idx_a];
    assign rdata_b_c = mem[idx_b];

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed symmetric FIR: accepts a sample, runs 16 shared-multiplier
// MAC steps over the coefficient pairs, then emits one saturated output.
module fir_mac_scheduler
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_in,
    output logic          sample_ready,
    output logic          filt_valid,
    output logic [DW-1:0] filt_out,
    output logic          busy,
    output logic          overrun
);

    fir_state_t            state, state_next;
    logic [KW-1:0]         k;
    logic [PW-1:0]         newest, wptr, idx_a, idx_b;
    logic [DW-1:0]         rdata_a, rdata_b;
    logic [DW:0]           pair_sum;
    logic [CW+DW:0]        product;
    logic [ACCW-1:0]       acc, acc_sum;
    logic [ACCW-SHIFT-1:0] scaled;
    logic [DW-1:0]         sat_val;
    logic                  accept, last_step;
    logic                  ready_d, busy_d, valid_d;

    assign accept    = (state == IDLE) && sample_valid;
    assign last_step = (k == KW'(NPAIR - 1));

    fir_sample_ring u_ring (
        .clk       (clk),
        .reset     (reset),
        .we        (accept),
        .wdata     (sample_in),
        .idx_a     (idx_a),
        .idx_b     (idx_b),
        .rdata_a_c (rdata_a),
        .rdata_b_c (rdata_b),
        .wptr      (wptr)
    );

    // Tap pair x[n-k] / x[n-30+k]; on the centre step both indices coincide
    assign idx_a    = ring_sub(newest, PW'(k));
    assign idx_b    = ring_sub(newest, PW'(NTAPS - 1) - PW'(k));
    assign pair_sum = last_step ? {1'b0, rdata_a}
                                : ({1'b0, rdata_a} + {1'b0, rdata_b});
    assign product  = (CW+DW+1)'(COEF[k]) * (CW+DW+1)'(pair_sum);
    assign acc_sum  = acc + ACCW'(product);
    assign scaled   = acc_sum[ACCW-1:SHIFT];
    assign sat_val  = (scaled > (ACCW-SHIFT)'((1 << DW) - 1)) ? '1 : scaled[DW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_valid) state_next = LOAD;
            LOAD:    state_next = MAC;
            MAC:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are registered from the state being entered
    always_comb begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        case (state_next)
            IDLE:     ready_d = 1'b1;
            LOAD,
            MAC:      busy_d  = 1'b1;
            DONE: begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
            end
            default:  ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_ready <= 1'b1;
            busy         <= 1'b0;
            filt_valid   <= 1'b0;
            filt_out     <= '0;
            overrun      <= 1'b0;
            acc          <= '0;
            k            <= '0;
            newest       <= '0;
        end else begin
            sample_ready <= ready_d;
            busy         <= busy_d;
            filt_valid   <= valid_d;
            if (sample_valid && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: if (accept) newest <= wptr;
                LOAD: begin
                    acc <= '0;
                    k   <= '0;
                end
                MAC: begin
                    acc <= acc_sum;
                    k   <= k + KW'(1);
                    if (last_step) filt_out <= sat_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Self-checking bench for fir_mac_scheduler: table vectors, direct-form
// reference model and a scoreboard of expected outputs with accept times.
module tb_fir_mac_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_valid;
    logic [9:0] sample_in;
    logic       sample_ready;
    logic       filt_valid;
    logic [9:0] filt_out;
    logic       busy;
    logic       overrun;

    fir_mac_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .sample_ready (sample_ready),
        .filt_valid   (filt_valid),
        .filt_out     (filt_out),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int exp;
        int acc_cyc;
    } sb_t;

    typedef struct {
        int sample;
        int exp;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = 0;
    sb_t  sbq[$];
    int   hist[$];
    int   h[31];
    int   coef_ref[16] = '{3, 4, 6, 8, 12, 17, 23, 29, 36, 43, 50, 56, 61, 65, 67, 68};
    vec_t imp_vec[32];
    bit   fv_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Direct-form reference over all 31 taps of the accepted history
    function automatic int model();
        int y = 0;
        int n = hist.size() - 1;
        for (int j = 0; j < 31; j++) begin
            if (n - j >= 0) y += h[j] * hist[n - j];
        end
        y = y >> 10;
        if (y > 1023) y = 1023;
        return y;
    endfunction

    always @(negedge clk) begin
        if (filt_valid) begin
            sb_t e;
            check("scoreboard_nonempty", int'(sbq.size() > 0), 1);
            check("pulse_width", int'(fv_prev), 0);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("filt_out", int'(filt_out), e.exp);
                check("latency", cyc - e.acc_cyc, 18);
            end
        end
        fv_prev = filt_valid;
    end

    task automatic send(input int v, input int exp_in, input bit use_model);
        int t = 0;
        int e;
        do begin
            @(negedge clk);
            t++;
        end while (!sample_ready && t < 200);
        if (!sample_ready) begin
            check("ready_timeout", int'(sample_ready), 1);
            return;
        end
        sample_valid = 1'b1;
        sample_in    = 10'(v);
        hist.push_back(v);
        e = use_model ? model() : exp_in;
        sbq.push_back('{e, cyc});
        last_acc = cyc;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() > 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("drain", sbq.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        sample_valid = 1'b0;
        sbq.delete();
        hist.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_sample_ready"}, int'(sample_ready), 1);
        check({tag, "_filt_valid"}, int'(filt_valid), 0);
        check({tag, "_filt_out"}, int'(filt_out), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        int imp_exp[32] = '{2, 3, 5, 7, 11, 16, 22, 28, 35, 42, 49, 55, 60, 64, 66, 67,
                            66, 64, 60, 55, 49, 42, 35, 28, 22, 16, 11, 7, 5, 3, 2, 0};
        int fv_count;
        int prev_acc;

        for (int j = 0; j < 31; j++) h[j] = (j <= 15) ? coef_ref[j] : coef_ref[30 - j];
        for (int i = 0; i < 32; i++) begin
            imp_vec[i].sample = (i == 0) ? 1023 : 0;
            imp_vec[i].exp    = imp_exp[i];
        end

        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_idle_state("reset");

        // DC level
        do_reset();
        for (int i = 0; i < 40; i++) send(512, 514, i < 30);
        drain();

        // Impulse response from the vector table
        do_reset();
        for (int i = 0; i < 32; i++) send(imp_vec[i].sample, imp_vec[i].exp, 1'b0);
        drain();

        // Full-scale input must clip, not wrap
        do_reset();
        for (int i = 0; i < 40; i++) send(1023, 1023, i < 30);
        drain();

        // Sample offered while busy is dropped and flags overrun
        do_reset();
        send(200, 0, 1'b1);
        check("ready_while_busy", int'(sample_ready), 0);
        check("busy_in_load", int'(busy), 1);
        sample_valid = 1'b1;
        sample_in    = 10'd999;
        @(negedge clk);
        sample_valid = 1'b0;
        check("overrun_set", int'(overrun), 1);
        drain();
        send(300, 0, 1'b1);
        drain();
        check("overrun_sticky", int'(overrun), 1);

        // Reset during MAC step 7 aborts the output and clears the ring
        send(700, 0, 1'b1);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        sbq.delete();
        hist.delete();
        @(negedge clk);
        reset = 1'b0;
        check_idle_state("abort");
        fv_count = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (filt_valid) fv_count++;
        end
        check("abort_no_output", fv_count, 0);
        send(100, 0, 1'b0);
        drain();

        // Ramp across two pointer wraps at full back-to-back rate
        do_reset();
        prev_acc = 0;
        for (int i = 0; i < 62; i++) begin
            send(i, 0, 1'b1);
            if (i > 0) check("throughput", last_acc - prev_acc, 19);
            prev_acc = last_acc;
        end
        drain();
        check("no_overrun_ramp", int'(overrun), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
